// File: rtl/arbitro_comparador_pkg.sv
// Shared types for the round-robin arbiter that fronts an external membership comparator.
// Holds the data width, the FSM encoding and the grant rule.
package arbitro_comparador_pkg;

    localparam int ANCHO_DATO = 6;

    typedef enum logic [1:0] {
        INACTIVO  = 2'd0,
        CONSULTA  = 2'd1,
        RESPUESTA = 2'd2
    } estado_t;

    // Winner id: a lone request wins outright; under contention the one not served last wins.
    function automatic logic elegir(input logic req0, input logic req1, input logic ultimo);
        if (req0 && req1) begin
            return ~ultimo;
        end
        return req1;
    endfunction

endpackage

// File: rtl/arbitro_comparador_if.sv
// Requester handshakes, comparator link, clear control and status of arbitro_comparador.
// The slave modport is the DUT view; master is the requester/environment view.
interface arbitro_comparador_if
    import arbitro_comparador_pkg::*;
#(
    parameter int ANCHO_CONTEO = 8
) ();

    logic                    req0;
    logic [ANCHO_DATO-1:0]   dato0;
    logic                    ack0;
    logic                    req1;
    logic [ANCHO_DATO-1:0]   dato1;
    logic                    ack1;
    logic                    resultado;
    logic [ANCHO_DATO-1:0]   comp_entrada;
    logic                    comp_salida;
    logic                    limpiar;
    logic [ANCHO_CONTEO-1:0] conteo0;
    logic [ANCHO_CONTEO-1:0] conteo1;
    logic                    ocupado;

    modport master (
        output req0, dato0, req1, dato1, comp_salida, limpiar,
        input  ack0, ack1, resultado, comp_entrada, conteo0, conteo1, ocupado
    );

    modport slave (
        input  req0, dato0, req1, dato1, comp_salida, limpiar,
        output ack0, ack1, resultado, comp_entrada, conteo0, conteo1, ocupado
    );

endinterface

// File: rtl/arbitro_comparador_contador_saturado.sv
// Hit counter that sticks at all-ones instead of wrapping.
// Reset and clear both zero it; clear beats a simultaneous increment.
module contador_saturado #(
    parameter int ANCHO = 8
) (
    input  logic             reloj,
    input  logic             reset,
    input  logic             limpiar,
    input  logic             incremento,
    output logic [ANCHO-1:0] conteo
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge reloj) begin
        if (reset || limpiar) begin
            conteo <= '0;
        end else if (incremento && (conteo != '1)) begin
            conteo <= conteo + 1'b1;
        end
    end

endmodule

// File: rtl/arbitro_comparador.sv
// Two-requester round-robin arbiter: one query in flight, three cycles per query,
// registered drive to the external comparator and a saturating hit count per requester.
module arbitro_comparador
    import arbitro_comparador_pkg::*;
#(
    parameter int ANCHO_CONTEO = 8
) (
    input logic                  reloj,
    input logic                  reset,
    arbitro_comparador_if.slave  bus
);

    estado_t estado;
    logic    id;
    logic    ultimo;
    logic    gana;
    logic    inc0;
    logic    inc1;

    assign gana        = elegir(bus.req0, bus.req1, ultimo);
    assign inc0        = (estado == CONSULTA) && bus.comp_salida && (id == 1'b0);
    assign inc1        = (estado == CONSULTA) && bus.comp_salida && (id == 1'b1);
    assign bus.ocupado = (estado != INACTIVO);

    always_ff @(posedge reloj) begin
        if (reset) begin
            estado           <= INACTIVO;
            id               <= 1'b0;
            ultimo           <= 1'b1;
            bus.comp_entrada <= '0;
            bus.resultado    <= 1'b0;
            bus.ack0         <= 1'b0;
            bus.ack1         <= 1'b0;
        end else begin
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            // NOTE: every case arm is covered and the default recovers, so no state can hold by accident.
            case (estado)
                INACTIVO: begin
                    if (bus.req0 || bus.req1) begin
                        id               <= gana;
                        bus.comp_entrada <= gana ? bus.dato1 : bus.dato0;
                        estado           <= CONSULTA;
                    end
                end
                CONSULTA: begin
                    bus.resultado <= bus.comp_salida;
                    estado        <= RESPUESTA;
                end
                RESPUESTA: begin
                    bus.ack0 <= ~id;
                    bus.ack1 <= id;
                    ultimo   <= id;
                    estado   <= INACTIVO;
                end
                default: estado <= INACTIVO;
            endcase
        end
    end

    contador_saturado #(.ANCHO(ANCHO_CONTEO)) u_conteo0 (
        .reloj      (reloj),
        .reset      (reset),
        .limpiar    (bus.limpiar),
        .incremento (inc0),
        .conteo     (bus.conteo0)
    );

    contador_saturado #(.ANCHO(ANCHO_CONTEO)) u_conteo1 (
        .reloj      (reloj),
        .reset      (reset),
        .limpiar    (bus.limpiar),
        .incremento (inc1),
        .conteo     (bus.conteo1)
    );

endmodule
